// File: rtl/vector_pkg.sv
// Shared types and sizes for the vector load path: lane geometry, register
// index width and the load-unit state encoding.
package vector_pkg;

   localparam int LANES     = 16;
   localparam int LANE_W    = 16;
   localparam int ADDR_W    = 16;
   localparam int REG_IDX_W = 5;
   localparam int IDX_W     = $clog2(LANES);

   typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      WRITE
   } vlu_state_t;

endpackage

// File: rtl/vector_load_unit.sv
// Gathers one strided vector from scalar data memory, one lane per cycle, and
// writes it into the vector register file as a single-cycle write pulse.
module vector_load_unit
   import vector_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [REG_IDX_W-1:0] vd,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W-1:0]    stride,
   output logic                 mem_re,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [LANE_W-1:0]    mem_rdata,
   output logic [REG_IDX_W-1:0] vrf_rd,
   output vec_t                 vrf_wd,
   output logic                 vrf_wev,
   output logic                 busy,
   output logic                 done
);

   vlu_state_t           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ADDR_W-1:0]    stride_q, stride_d;
   logic [REG_IDX_W-1:0] vd_q, vd_d;
   logic                 cap_vld_q;
   logic [IDX_W-1:0]     cap_idx_q;
   vec_t                 lane_buf_q, lane_buf_d;
   vec_t                 vrf_wd_q, vrf_wd_d;
   logic [REG_IDX_W-1:0] vrf_rd_q, vrf_rd_d;

   // NOTE: every variable gets its hold value first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      stride_d   = stride_q;
      vd_d       = vd_q;
      lane_buf_d = lane_buf_q;
      vrf_wd_d   = vrf_wd_q;
      vrf_rd_d   = vrf_rd_q;

      // Read data belongs to the lane issued one cycle earlier.
      if (cap_vld_q) lane_buf_d[cap_idx_q] = mem_rdata;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = FETCH;
               addr_d   = base_addr;
               stride_d = stride;
               vd_d     = vd;
               idx_d    = '0;
            end
         end
         FETCH: begin
            addr_d = addr_q + stride_q;
            idx_d  = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(LANES - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            state_d  = WRITE;
            vrf_wd_d = lane_buf_d;
            vrf_rd_d = vd_q;
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the lane buffer is a small flop array, so it is cleared on reset like any other state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         addr_q     <= '0;
         stride_q   <= '0;
         vd_q       <= '0;
         cap_vld_q  <= 1'b0;
         cap_idx_q  <= '0;
         lane_buf_q <= '0;
         vrf_wd_q   <= '0;
         vrf_rd_q   <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         stride_q   <= stride_d;
         vd_q       <= vd_d;
         cap_vld_q  <= (state_q == FETCH);
         cap_idx_q  <= idx_q;
         lane_buf_q <= lane_buf_d;
         vrf_wd_q   <= vrf_wd_d;
         vrf_rd_q   <= vrf_rd_d;
      end
   end

   assign mem_re   = (state_q == FETCH);
   assign mem_addr = addr_q;
   assign vrf_wev  = (state_q == WRITE);
   assign done     = (state_q == WRITE);
   assign busy     = (state_q != IDLE);
   assign vrf_wd   = vrf_wd_q;
   assign vrf_rd   = vrf_rd_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed bench for vector_load_unit: a memory model answers reads one cycle
// late, and a scoreboard of expected addresses and RF writes checks the DUT.
module tb_vector_load_unit;
   import vector_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [REG_IDX_W-1:0] vd;
   logic [ADDR_W-1:0]    base_addr;
   logic [ADDR_W-1:0]    stride;
   logic                 mem_re;
   logic [ADDR_W-1:0]    mem_addr;
   logic [LANE_W-1:0]    mem_rdata;
   logic [REG_IDX_W-1:0] vrf_rd;
   vec_t                 vrf_wd;
   logic                 vrf_wev;
   logic                 busy;
   logic                 done;

   typedef struct {
      logic [ADDR_W-1:0] a;
      int                cyc;
   } addr_exp_t;

   typedef struct {
      logic [REG_IDX_W-1:0] rd;
      vec_t                 wd;
      int                   cyc;
   } wr_exp_t;

   addr_exp_t         exp_addr[$];
   wr_exp_t           exp_wr[$];
   logic [LANE_W-1:0] mem [65536];
   int                cyc    = 0;
   int                n_chk  = 0;
   int                n_fail = 0;

   vector_load_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .vd        (vd),
      .base_addr (base_addr),
      .stride    (stride),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .vrf_rd    (vrf_rd),
      .vrf_wd    (vrf_wd),
      .vrf_wev   (vrf_wev),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle read latency; junk when not reading so stray captures show up.
   always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : 16'hDEAD;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [REG_IDX_W-1:0] v, input logic [ADDR_W-1:0] b,
                        input logic [ADDR_W-1:0] s, input bit accept);
      addr_exp_t ae;
      wr_exp_t   we;
      vec_t      w;
      vd        = v;
      base_addr = b;
      stride    = s;
      start     = 1'b1;
      if (accept) begin
         for (int i = 0; i < LANES; i++) begin
            ae.a   = b + ADDR_W'(i) * s;
            ae.cyc = cyc + 1 + i;
            exp_addr.push_back(ae);
            w[i] = mem[ae.a];
         end
         we.rd  = v;
         we.wd  = w;
         we.cyc = cyc + LANES + 2;
         exp_wr.push_back(we);
      end
      tick();
      start     = 1'b0;
      vd        = REG_IDX_W'($urandom);
      base_addr = ADDR_W'($urandom);
      stride    = ADDR_W'($urandom);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         tick();
         seen = done;
      end
      check("done_timeout", seen, 1);
   endtask

   task automatic wait_drain();
      bit idle = 1'b0;
      for (int k = 0; k < 60 && !idle; k++) begin
         tick();
         idle = !busy && exp_addr.size() == 0 && exp_wr.size() == 0;
      end
      check("addr_queue_empty", exp_addr.size(), 0);
      check("write_queue_empty", exp_wr.size(), 0);
      check("busy_after_drain", busy, 0);
   endtask

   // Scoreboard monitor, sampled away from the rising edge.
   always @(negedge clk) begin
      addr_exp_t ae;
      wr_exp_t   we;
      if (rst === 1'b1) begin
         if (mem_re === 1'b1) begin
            if (exp_addr.size() == 0) check("unexpected_mem_re", 1, 0);
            else begin
               ae = exp_addr.pop_front();
               check("mem_addr", mem_addr, ae.a);
               check("mem_re_cycle", cyc, ae.cyc);
            end
         end
         if (vrf_wev === 1'b1) begin
            if (exp_wr.size() == 0) check("unexpected_vrf_wev", 1, 0);
            else begin
               we = exp_wr.pop_front();
               check("vrf_rd", vrf_rd, we.rd);
               check("vrf_wd", vrf_wd, we.wd);
               check("vrf_wev_cycle", cyc, we.cyc);
            end
         end
         if (vrf_wev !== 1'b0 || done !== 1'b0) check("done_with_wev", done, vrf_wev);
      end
   end

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      vd        = '0;
      base_addr = '0;
      stride    = '0;
      for (int i = 0; i < 65536; i++) mem[i] = LANE_W'($urandom);
      for (int i = 0; i < LANES; i++) mem[16'h0100 + i] = LANE_W'(16'h1000 + i);
      mem[16'h0020] = 16'hABCD;

      // Reset state.
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_vrf_wev", vrf_wev, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_vrf_rd", vrf_rd, 0);
      check("rst_vrf_wd", vrf_wd, 0);
      rst = 1'b1;
      repeat (4) tick();
      check("idle_busy", busy, 0);

      // Unit stride with a rejected request mid-load, a start during WRITE,
      // then a back-to-back start in the first idle cycle.
      issue(5'd5, 16'h0100, 16'd1, 1'b1);
      repeat (3) tick();
      check("busy_during_load", busy, 1);
      issue(5'd7, 16'h0300, 16'd2, 1'b0);
      wait_done();
      issue(5'd9, 16'h0400, 16'd1, 1'b0);
      issue(5'd10, 16'h0200, 16'd3, 1'b1);
      wait_drain();
      repeat (3) tick();
      check("vrf_rd_hold", vrf_rd, 10);

      // Abort mid-fetch: pending work and responses are dropped.
      issue(5'd3, 16'h0040, 16'd3, 1'b1);
      repeat (8) tick();
      rst = 1'b0;
      exp_addr.delete();
      exp_wr.delete();
      tick();
      check("abort_busy", busy, 0);
      check("abort_mem_re", mem_re, 0);
      check("abort_vrf_wev", vrf_wev, 0);
      check("abort_vrf_rd", vrf_rd, 0);
      rst = 1'b1;
      repeat (25) tick();

      // Broadcast after abort.
      issue(5'd31, 16'h0020, 16'd0, 1'b1);
      wait_done();
      wait_drain();

      // Strided load wrapping past the top of the address space.
      issue(5'd1, 16'hFFF8, 16'd4, 1'b1);
      wait_done();
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
